// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Groups every non-clock signal of mem_port_arbiter into one interface.
//   Fetch requester : if_req, if_addr -> if_rdata, if_ready
//   Data requester  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ready
//   Memory port     : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   Pipeline status : pipe_stall, owner
// Modports:
//   slave  - the arbiter's view (takes requests and mem_rdata, drives the rest)
//   master - the environment's view (pipeline plus memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              pipe_stall;
   logic [1:0]        owner;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ready, dm_rdata, dm_ready,
             mem_en, mem_we, mem_addr, mem_wdata, pipe_stall, owner
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
             mem_en, mem_we, mem_addr, mem_wdata, pipe_stall, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch requester and the data requester. One access is in flight at a time:
// grant in IDLE, one mem_en strobe, wait MEM_LATENCY cycles for mem_rdata,
// then a single-cycle ready pulse. Data has priority, but after STARVE_LIMIT
// consecutive data grants with a fetch waiting, the fetch wins once.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (requesters, memory, pipe_stall, owner)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY);
   localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      DONE_I = 3'd3,
      DONE_D = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic [3:0]        streak_r, streak_s;
   logic              grant_i_s, grant_d_s;
   logic [1:0]        owner_s;

   logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
   logic [DATA_W-1:0] dm_rdata_r, dm_rdata_s;
   logic              if_ready_r, if_ready_s;
   logic              dm_ready_r, dm_ready_s;
   logic              mem_en_r, mem_en_s;
   logic              mem_we_r, mem_we_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

   // State register: FSM state, latency counter and starvation streak.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= 4'd0;
         streak_r <= 4'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         streak_r <= streak_s;
      end
   end

   // Next-state logic: arbitration in IDLE and latency countdown while busy.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      streak_s  = streak_r;
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      case (state_r)
         IDLE: begin
            // Data wins unless a waiting fetch has already lost STARVE_LIMIT times.
            if (bus.dm_req && !(bus.if_req && (streak_r == STREAK_MAX))) begin
               grant_d_s = 1'b1;
               state_s   = BUSY_D;
               cnt_s     = LAT_LOAD;
               if (bus.if_req) begin
                  streak_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + 4'd1;
               end else begin
                  streak_s = 4'd0;
               end
            end else if (bus.if_req) begin
               grant_i_s = 1'b1;
               state_s   = BUSY_I;
               cnt_s     = LAT_LOAD;
               streak_s  = 4'd0;
            end else begin
               state_s   = IDLE;
            end
         end
         // Counter hits zero in the cycle where mem_rdata is valid.
         BUSY_I: begin
            if (cnt_r == 4'd0) begin
               state_s = DONE_I;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         BUSY_D: begin
            if (cnt_r == 4'd0) begin
               state_s = DONE_D;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         // No re-grant from DONE: always pass through IDLE first.
         DONE_I, DONE_D: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered memory strobe and responses.
   always_comb begin
      if_rdata_s  = if_rdata_r;
      dm_rdata_s  = dm_rdata_r;
      if_ready_s  = 1'b0;
      dm_ready_s  = 1'b0;
      mem_en_s    = 1'b0;
      mem_we_s    = mem_we_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      if (grant_d_s) begin
         mem_en_s    = 1'b1;
         mem_we_s    = bus.dm_we;
         mem_addr_s  = bus.dm_addr;
         mem_wdata_s = bus.dm_wdata;
      end else if (grant_i_s) begin
         mem_en_s    = 1'b1;
         mem_we_s    = 1'b0;
         mem_addr_s  = bus.if_addr;
      end else if ((state_r == BUSY_I) && (cnt_r == 4'd0)) begin
         if_rdata_s  = bus.mem_rdata;
         if_ready_s  = 1'b1;
         mem_we_s    = 1'b0;
      end else if ((state_r == BUSY_D) && (cnt_r == 4'd0)) begin
         // mem_we still holds the granted direction; stores leave dm_rdata alone.
         if (!mem_we_r) begin
            dm_rdata_s = bus.mem_rdata;
         end else begin
            dm_rdata_s = dm_rdata_r;
         end
         dm_ready_s  = 1'b1;
         mem_we_s    = 1'b0;
      end else begin
         mem_we_s    = mem_we_r;
      end
   end

   // Output register: every memory-side and response output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata_r  <= '0;
         dm_rdata_r  <= '0;
         if_ready_r  <= 1'b0;
         dm_ready_r  <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else begin
         if_rdata_r  <= if_rdata_s;
         dm_rdata_r  <= dm_rdata_s;
         if_ready_r  <= if_ready_s;
         dm_ready_r  <= dm_ready_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
      end
   end

   // Owner decode: which requester currently holds the memory port.
   always_comb begin
      case (state_r)
         BUSY_I, DONE_I: owner_s = 2'b01;
         BUSY_D, DONE_D: owner_s = 2'b10;
         default:        owner_s = 2'b00;
      endcase
   end

   assign bus.if_rdata   = if_rdata_r;
   assign bus.dm_rdata   = dm_rdata_r;
   assign bus.if_ready   = if_ready_r;
   assign bus.dm_ready   = dm_ready_r;
   assign bus.mem_en     = mem_en_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.owner      = owner_s;
   assign bus.pipe_stall = (bus.if_req & ~if_ready_r) | (bus.dm_req & ~dm_ready_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=2).
// A fixed-latency memory model answers the DUT's strobes; a transaction-level
// model predicts every output each cycle; directed steps add literal checks.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LAT    = 2;
   localparam int SLIM   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int c0      = 0;

   logic [31:0] mem   [logic [31:0]];
   logic [31:0] sched [int];
   logic [1:0]  grant_q [$];
   logic [1:0]  exp_order [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_b(input string name, input logic got, input logic exp);
      check(name, 32'(got), 32'(exp));
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      else return a ^ 32'hA5A5_0000;
   endfunction

   // Memory read-data driver: presents scheduled data exactly LAT cycles after mem_en.
   initial begin
      bus.mem_rdata = 32'hBAD0_BAD0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sched.exists(cyc)) begin
            bus.mem_rdata = sched[cyc];
            sched.delete(cyc);
         end else begin
            bus.mem_rdata = 32'hBAD0_BAD0;
         end
      end
   end

   // Transaction-level model and per-cycle compare.
   bit          m_valid = 1'b0, m_busy = 1'b0, m_just_reset = 1'b0;
   bit          m_who_d, m_we;
   int          m_g, m_streak = 0, m_d;
   logic [31:0] m_addr, m_wdata, m_val;
   logic [31:0] e_if_rdata = 32'd0, e_dm_rdata = 32'd0;
   logic        e_en, e_ifr, e_dmr;
   logic [1:0]  e_own;

   initial begin
      forever begin
         @(negedge clk);
         e_en = 1'b0; e_ifr = 1'b0; e_dmr = 1'b0; e_own = 2'b00; m_d = 0;
         if (m_busy) begin
            m_d   = cyc - m_g;
            e_own = m_who_d ? 2'b10 : 2'b01;
            e_en  = (m_d == 1);
            if (m_d == LAT + 2) begin
               if (m_who_d) e_dmr = 1'b1;
               else         e_ifr = 1'b1;
            end
         end
         if (m_valid) begin
            check_b("mem_en", bus.mem_en, e_en);
            check("owner", 32'(bus.owner), 32'(e_own));
            check_b("if_ready", bus.if_ready, e_ifr);
            check_b("dm_ready", bus.dm_ready, e_dmr);
            check("if_rdata", bus.if_rdata, e_if_rdata);
            check("dm_rdata", bus.dm_rdata, e_dm_rdata);
            check_b("pipe_stall", bus.pipe_stall,
                    (bus.if_req & ~e_ifr) | (bus.dm_req & ~e_dmr));
            if (m_busy && m_d == 1) begin
               check("mem_addr", bus.mem_addr, m_addr);
               check_b("mem_we", bus.mem_we, m_we);
               if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (m_busy && m_d == LAT + 2) check_b("mem_we_done", bus.mem_we, 1'b0);
            if (m_just_reset) begin
               check("rst_mem_addr", bus.mem_addr, 32'd0);
               check("rst_mem_wdata", bus.mem_wdata, 32'd0);
               check_b("rst_mem_we", bus.mem_we, 1'b0);
            end
         end
         if (bus.mem_en === 1'b1) begin
            grant_q.push_back(bus.owner);
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else            sched[cyc + LAT] = mem_read(bus.mem_addr);
         end
         // Advance the model across the coming clock edge.
         m_just_reset = 1'b0;
         if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_streak = 0;
            e_if_rdata = 32'd0; e_dm_rdata = 32'd0; m_just_reset = 1'b1;
         end else if (m_valid) begin
            if (!m_busy) begin
               if (bus.dm_req && !(bus.if_req && m_streak == SLIM)) begin
                  m_busy = 1'b1; m_who_d = 1'b1; m_g = cyc;
                  m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                  m_streak = bus.if_req ? ((m_streak < SLIM) ? m_streak + 1 : SLIM) : 0;
               end else if (bus.if_req) begin
                  m_busy = 1'b1; m_who_d = 1'b0; m_g = cyc;
                  m_we = 1'b0; m_addr = bus.if_addr; m_streak = 0;
               end
               if (m_busy) m_val = mem_read(m_addr);
            end else begin
               if (m_d == LAT + 1 && !m_we) begin
                  if (m_who_d) e_dm_rdata = m_val;
                  else         e_if_rdata = m_val;
               end
               if (m_d == LAT + 2) m_busy = 1'b0;
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #3;
   endtask

   task automatic at_cycle(input int k);
      while (cyc < c0 + k) next_cycle();
   endtask

   // Watchdog: the directed sequence is short, so this only fires on a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus with literal expectations.
   initial begin
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'd0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
      mem[32'h40] = 32'h2002_000A;
      mem[32'h10] = 32'h1111_0010;
      c0 = 0;
      at_cycle(2); rst = 1'b0;
      at_cycle(3);
      check_b("reset_mem_en", bus.mem_en, 1'b0);
      check("reset_owner", 32'(bus.owner), 32'd0);
      check("reset_if_rdata", bus.if_rdata, 32'd0);
      at_cycle(5);

      // Single fetch
      c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h40;
      at_cycle(1);
      check_b("t1_mem_en_c1", bus.mem_en, 1'b1);
      check("t1_mem_addr", bus.mem_addr, 32'h40);
      check_b("t1_mem_we", bus.mem_we, 1'b0);
      at_cycle(2); check_b("t1_mem_en_c2", bus.mem_en, 1'b0);
      at_cycle(3); check_b("t1_stall_c3", bus.pipe_stall, 1'b1);
      at_cycle(4);
      check_b("t1_if_ready", bus.if_ready, 1'b1);
      check("t1_if_rdata", bus.if_rdata, 32'h2002_000A);
      check_b("t1_stall_c4", bus.pipe_stall, 1'b0);
      at_cycle(5); check_b("t1_ready_once", bus.if_ready, 1'b0); bus.if_req = 1'b0;
      at_cycle(7);

      // Simultaneous requests: data first, then fetch
      c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h44;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
      at_cycle(1); check("t2_owner_d", 32'(bus.owner), 32'h2);
      at_cycle(4);
      check_b("t2_dm_ready", bus.dm_ready, 1'b1);
      check("t2_dm_rdata", bus.dm_rdata, 32'h1111_0010);
      at_cycle(5); bus.dm_req = 1'b0;
      at_cycle(6);
      check_b("t2_mem_en_c6", bus.mem_en, 1'b1);
      check("t2_owner_i", 32'(bus.owner), 32'h1);
      at_cycle(9);
      check_b("t2_if_ready", bus.if_ready, 1'b1);
      check("t2_if_rdata", bus.if_rdata, 32'hA5A5_0044);
      at_cycle(10); bus.if_req = 1'b0;
      at_cycle(12);

      // Store; post-grant address/data changes must be ignored
      c0 = cyc; bus.dm_req = 1'b1; bus.dm_we = 1'b1;
      bus.dm_addr = 32'h14; bus.dm_wdata = 32'hDEAD_BEEF;
      at_cycle(1);
      check_b("t3_mem_en", bus.mem_en, 1'b1);
      check_b("t3_mem_we", bus.mem_we, 1'b1);
      check("t3_mem_addr", bus.mem_addr, 32'h14);
      check("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      at_cycle(2); bus.dm_addr = 32'h99; bus.dm_wdata = 32'd0;
      at_cycle(4);
      check_b("t3_dm_ready", bus.dm_ready, 1'b1);
      check("t3_dm_rdata_kept", bus.dm_rdata, 32'h1111_0010);
      check_b("t3_mem_we_done", bus.mem_we, 1'b0);
      at_cycle(5); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      at_cycle(7);
      // Read the stored word back
      c0 = cyc; bus.dm_req = 1'b1; bus.dm_addr = 32'h14;
      at_cycle(4); check("t3_readback", bus.dm_rdata, 32'hDEAD_BEEF);
      at_cycle(5); bus.dm_req = 1'b0;
      at_cycle(7);

      // Starvation bound with both requesters held for six grants
      grant_q.delete();
      c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h80;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h84;
      at_cycle(30); bus.if_req = 1'b0; bus.dm_req = 1'b0;
      at_cycle(32);
      check("t4_grant_count", 32'(grant_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < grant_q.size()) check($sformatf("t4_grant_%0d", i), 32'(grant_q[i]), 32'(exp_order[i]));
         else check($sformatf("t4_grant_%0d", i), 32'hFFFF_FFFF, 32'(exp_order[i]));
      end

      // Reset while BUSY_D
      c0 = cyc; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
      at_cycle(2); rst = 1'b1; bus.dm_req = 1'b0;
      at_cycle(3); rst = 1'b0;
      check("t5_owner", 32'(bus.owner), 32'd0);
      check_b("t5_mem_en", bus.mem_en, 1'b0);
      check_b("t5_dm_ready_c3", bus.dm_ready, 1'b0);
      at_cycle(4); check_b("t5_dm_ready_c4", bus.dm_ready, 1'b0);
      at_cycle(6);
      c0 = cyc; bus.dm_req = 1'b1; bus.dm_addr = 32'h24;
      at_cycle(1); check_b("t5_regrant", bus.mem_en, 1'b1);
      at_cycle(4);
      check_b("t5_dm_ready", bus.dm_ready, 1'b1);
      check("t5_dm_rdata", bus.dm_rdata, 32'hA5A5_0024);
      at_cycle(5); bus.dm_req = 1'b0;
      at_cycle(7);

      // Fetch request dropped mid-transaction
      c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h48;
      at_cycle(2); bus.if_req = 1'b0; bus.if_addr = 32'h4C;
      at_cycle(4);
      check_b("t6_if_ready", bus.if_ready, 1'b1);
      check("t6_if_rdata", bus.if_rdata, 32'hA5A5_0048);
      for (int k = 5; k < 10; k++) begin
         at_cycle(k);
         check_b($sformatf("t6_no_mem_en_c%0d", k), bus.mem_en, 1'b0);
      end
      at_cycle(11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
